// File: rtl/fe_capture_encoder.sv
// Capture writer between the USB sniffer and the sniff FIFO: turns sniffed bytes and
// line-status changes into DATA/STAT/TIME entries with compressed timestamps.
module fe_capture_encoder #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             I_arm,
  input  logic                             I_timestamps_disable,
  input  logic [15:0]                      I_capture_len,
  input  logic                             I_fifo_full,
  input  logic [7:0]                       I_sniff_data,
  input  logic                             I_sniff_valid,
  input  logic [4:0]                       I_sniff_stat,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_capture_time,
  output logic [7:0]                       O_capture_data,
  output logic [4:0]                       O_capture_stat,
  output logic [1:0]                       O_capture_cmd,
  output logic                             O_capture_data_wr,
  output logic                             O_capturing,
  output logic                             O_done,
  output logic                             O_dropped
);
  localparam int TW = pTIMESTAMP_FULL_WIDTH;
  localparam int SW = pTIMESTAMP_SHORT_WIDTH;
  localparam logic [TW-1:0] SHORT_MAX = {{(TW-SW){1'b0}}, {SW{1'b1}}};
  localparam logic [TW-1:0] TS_MAX    = '1;
  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_STAT = 2'd1;
  localparam logic [1:0] CMD_TIME = 2'd2;

  typedef enum logic [2:0] {IDLE, WAIT_START, CAPTURE, TIME_PEND, DONE} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   ts, ts_n, ts_inc;
  logic [15:0]     count, count_n, len_q, len_n;
  logic [4:0]      last_stat, last_stat_n;
  logic [1:0]      hold_cmd, hold_cmd_n;
  logic [7:0]      hold_data, hold_data_n;
  logic [4:0]      hold_stat, hold_stat_n;
  logic            dropped, dropped_n;
  logic            ev;
  logic [1:0]      ev_cmd;
  logic [7:0]      ev_data;
  logic            emit;
  logic [1:0]      e_cmd;
  logic [TW-1:0]   e_time;
  logic [7:0]      e_data;
  logic [4:0]      e_stat;

  // FIFO full is flagged by the register block; entries are emitted regardless.
  logic unused_fifo_full;
  assign unused_fifo_full = I_fifo_full;

  assign ev      = I_sniff_valid || (I_sniff_stat != last_stat);
  assign ev_cmd  = I_sniff_valid ? CMD_DATA : CMD_STAT;
  assign ev_data = I_sniff_valid ? I_sniff_data : 8'd0;
  assign ts_inc  = (ts == TS_MAX) ? ts : ts + TW'(1);

  always_comb begin
    state_n     = state;
    ts_n        = ts;
    count_n     = count;
    len_n       = len_q;
    last_stat_n = last_stat;
    hold_cmd_n  = hold_cmd;
    hold_data_n = hold_data;
    hold_stat_n = hold_stat;
    dropped_n   = dropped;
    emit        = 1'b0;
    e_cmd       = CMD_DATA;
    e_time      = '0;
    e_data      = '0;
    e_stat      = '0;
    if (state != IDLE && !I_arm) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          len_n = I_capture_len;
          if (I_arm) begin
            state_n   = WAIT_START;
            count_n   = '0;
            dropped_n = 1'b0;
          end
        end
        WAIT_START: begin
          if (ev) begin
            emit        = 1'b1;
            e_cmd       = ev_cmd;
            e_data      = ev_data;
            e_stat      = I_sniff_stat;
            last_stat_n = I_sniff_stat;
            ts_n        = '0;
            state_n     = CAPTURE;
          end
        end
        CAPTURE: begin
          ts_n = ts_inc;
          if (ev) begin
            // last_stat follows accepted events (held ones too) so a held status
            // change is not seen again as a fresh event in TIME_PEND.
            emit        = 1'b1;
            last_stat_n = I_sniff_stat;
            ts_n        = '0;
            if (I_timestamps_disable || ts_inc <= SHORT_MAX) begin
              e_cmd  = ev_cmd;
              e_data = ev_data;
              e_stat = I_sniff_stat;
              if (!I_timestamps_disable) e_time = {{(TW-SW){1'b0}}, ts_inc[SW-1:0]};
            end else begin
              e_cmd       = CMD_TIME;
              e_time      = ts_inc;
              hold_cmd_n  = ev_cmd;
              hold_data_n = ev_data;
              hold_stat_n = I_sniff_stat;
              state_n     = TIME_PEND;
            end
          end else if (!I_timestamps_disable && ts_inc == TS_MAX) begin
            emit   = 1'b1;
            e_cmd  = CMD_TIME;
            e_time = TS_MAX;
            ts_n   = '0;
          end
        end
        TIME_PEND: begin
          ts_n    = ts_inc;
          emit    = 1'b1;
          e_cmd   = hold_cmd;
          e_data  = hold_data;
          e_stat  = hold_stat;
          state_n = CAPTURE;
          if (ev) dropped_n = 1'b1;
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
      // Reaching the limit wins over TIME_PEND, discarding any held event.
      if (emit) begin
        count_n = count + 16'd1;
        if (len_q != 16'd0 && count_n == len_q) state_n = DONE;
      end
    end
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state             <= IDLE;
      ts                <= '0;
      count             <= '0;
      len_q             <= '0;
      last_stat         <= '0;
      hold_cmd          <= '0;
      hold_data         <= '0;
      hold_stat         <= '0;
      dropped           <= 1'b0;
      O_capture_data_wr <= 1'b0;
      O_capture_cmd     <= '0;
      O_capture_time    <= '0;
      O_capture_data    <= '0;
      O_capture_stat    <= '0;
    end else begin
      state             <= state_n;
      ts                <= ts_n;
      count             <= count_n;
      len_q             <= len_n;
      last_stat         <= last_stat_n;
      hold_cmd          <= hold_cmd_n;
      hold_data         <= hold_data_n;
      hold_stat         <= hold_stat_n;
      dropped           <= dropped_n;
      O_capture_data_wr <= emit;
      O_capture_cmd     <= e_cmd;
      O_capture_time    <= e_time;
      O_capture_data    <= e_data;
      O_capture_stat    <= e_stat;
    end
  end

  assign O_capturing = (state == WAIT_START) || (state == CAPTURE) || (state == TIME_PEND);
  assign O_done      = (state == DONE);
  assign O_dropped   = dropped;
endmodule

// File: tb/tb_fe_capture_encoder.sv
// Randomized bench for fe_capture_encoder against a cycle-time reference model
// that measures gaps as differences of absolute cycle numbers.
module tb_fe_capture_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, dis, full, valid;
  logic [15:0] len;
  logic [7:0]  data;
  logic [4:0]  stat;
  logic [15:0] o_time;
  logic [7:0]  o_data;
  logic [4:0]  o_stat;
  logic [1:0]  o_cmd;
  logic        o_wr, o_capturing, o_done, o_dropped;

  fe_capture_encoder dut (
    .fe_clk(clk), .reset_i(rst), .I_arm(arm), .I_timestamps_disable(dis),
    .I_capture_len(len), .I_fifo_full(full), .I_sniff_data(data),
    .I_sniff_valid(valid), .I_sniff_stat(stat),
    .O_capture_time(o_time), .O_capture_data(o_data), .O_capture_stat(o_stat),
    .O_capture_cmd(o_cmd), .O_capture_data_wr(o_wr), .O_capturing(o_capturing),
    .O_done(o_done), .O_dropped(o_dropped)
  );

  localparam logic [1:0] C_DATA = 2'd0, C_STAT = 2'd1, C_TIME = 2'd2;

  int n_cmp = 0, n_bad = 0, wr_seen = 0;

  // Reference model state
  bit         m_sess, m_started, m_pend, m_done, m_drop;
  int         m_cnt, m_len, m_ref, cyc;
  logic [4:0] m_last;
  logic [1:0] h_cmd;
  logic [7:0] h_data;
  logic [4:0] h_stat;
  bit         x_wr;
  logic [1:0] x_cmd;
  int         x_time;
  logic [7:0] x_data;
  logic [4:0] x_stat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic put(input logic [1:0] c, input int t, input logic [7:0] d, input logic [4:0] s);
    x_wr = 1; x_cmd = c; x_time = t; x_data = d; x_stat = s;
    m_cnt++;
  endtask

  task automatic model_step();
    bit ev;
    logic [1:0] ec;
    logic [7:0] ed;
    int d;
    cyc++;
    x_wr = 0;
    if (rst) begin
      m_sess = 0; m_started = 0; m_pend = 0; m_done = 0; m_drop = 0;
      m_cnt = 0; m_len = 0; m_last = '0;
    end else if (!m_sess) begin
      m_len = int'(len);
      if (arm) begin
        m_sess = 1; m_started = 0; m_pend = 0; m_done = 0; m_drop = 0; m_cnt = 0;
      end
    end else if (!arm) begin
      m_sess = 0; m_started = 0; m_pend = 0; m_done = 0;
    end else if (!m_done) begin
      ev = valid || (stat != m_last);
      ec = valid ? C_DATA : C_STAT;
      ed = valid ? data : 8'd0;
      if (m_pend) begin
        put(h_cmd, 0, h_data, h_stat);
        m_pend = 0;
        if (ev) m_drop = 1;
      end else if (!m_started) begin
        if (ev) begin
          put(ec, 0, ed, stat);
          m_started = 1; m_ref = cyc; m_last = stat;
        end
      end else begin
        d = cyc - m_ref;
        if (d > 65535) d = 65535;
        if (ev) begin
          m_last = stat; m_ref = cyc;
          if (dis || d <= 7) put(ec, dis ? 0 : d, ed, stat);
          else begin
            put(C_TIME, d, 8'd0, 5'd0);
            h_cmd = ec; h_data = ed; h_stat = stat; m_pend = 1;
          end
        end else if (!dis && d == 65535) begin
          put(C_TIME, 65535, 8'd0, 5'd0);
          m_ref = cyc;
        end
      end
      if (x_wr && m_len != 0 && (m_cnt % 65536) == m_len) begin
        m_done = 1; m_pend = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr", 32'(o_wr), 32'(x_wr));
    if (o_wr) wr_seen++;
    if (x_wr) begin
      chk("cmd", 32'(o_cmd), 32'(x_cmd));
      chk("time", 32'(o_time), 32'(x_time));
      chk("data", 32'(o_data), 32'(x_data));
      chk("stat", 32'(o_stat), 32'(x_stat));
    end
    chk("capturing", 32'(o_capturing), 32'(m_sess && !m_done));
    chk("done", 32'(o_done), 32'(m_done));
    chk("dropped", 32'(o_dropped), 32'(m_drop));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    valid = 1; data = b;
    tick();
    valid = 0;
  endtask

  task automatic rearm();
    arm = 0; tick();
    arm = 1; tick();
  endtask

  int w0;

  initial begin
    rst = 1; arm = 0; dis = 0; full = 0; valid = 0; len = 0; data = 0; stat = 0;
    cyc = 0;
    tick(); tick();
    chk("rst_time", 32'(o_time), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_stat", 32'(o_stat), 0);
    chk("rst_cmd", 32'(o_cmd), 0);
    rst = 0; tick();

    // Two bytes 5 cycles apart
    arm = 1; tick();
    send(8'h11); idle(4); send(8'h22); idle(2);
    chk("plan1_capturing", 32'(o_capturing), 1);

    // Gap of 20 cycles: TIME entry then held DATA
    rearm();
    send(8'h33); idle(19); w0 = wr_seen; send(8'h44); idle(2);
    chk("plan2_entries", 32'(wr_seen - w0), 2);

    // Idle overflow
    rearm();
    send(8'h55);
    w0 = wr_seen; idle(70000);
    chk("ovf_entries", 32'(wr_seen - w0), 1);
    send(8'h66); idle(2);

    // Length limit of 4
    arm = 0; len = 16'd4; tick();
    arm = 1; tick();
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) begin send(8'(i + 1)); idle(1); end
    idle(2);
    chk("len4_entries", 32'(wr_seen - w0), 4);
    chk("len4_done", 32'(o_done), 1);
    chk("len4_capturing", 32'(o_capturing), 0);
    arm = 0; tick();
    chk("len4_abort_done", 32'(o_done), 0);
    len = 0; tick();

    // Status-only change then status change with byte, with and without timestamps
    for (int k = 0; k < 2; k++) begin
      dis = (k == 0);
      stat = 5'd0; arm = 0; tick();
      arm = 1; tick();
      stat = 5'd3; tick(); idle(3);
      stat = 5'd5; send(8'h77); idle(20);
      stat = 5'd6; tick(); idle(2);
      arm = 0; tick();
    end
    dis = 0;

    // Byte arriving during TIME_PEND is lost
    arm = 1; tick();
    send(8'h01); idle(8); send(8'h02); send(8'h03); idle(2);
    chk("drop_sticky", 32'(o_dropped), 1);
    rearm();
    chk("drop_cleared", 32'(o_dropped), 0);

    // Randomized sessions
    for (int s = 0; s < 30; s++) begin
      arm = 0; len = 16'($urandom_range(0, 6)); dis = ($urandom % 4 == 0);
      tick();
      arm = 1;
      for (int c = 0; c < $urandom_range(40, 140); c++) begin
        full  = ($urandom % 3 == 0);
        valid = ($urandom % 3 == 0);
        data  = 8'($urandom);
        if ($urandom % 8 == 0) stat = 5'($urandom);
        if ($urandom % 90 == 0) arm = ~arm;
        rst = ($urandom % 300 == 0);
        tick();
        rst = 0;
        if ($urandom % 12 == 0) idle($urandom_range(5, 30));
      end
    end
    arm = 0; valid = 0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fe_capture_encoder.md
Name: fe_capture_encoder

Overview:
- Front-end capture writer that sits between the USB sniffer and the sniff-FIFO write port of the register block.
- Converts sniffed bytes and line-status changes into capture entries tagged with a command code (DATA, STAT or TIME) and a timestamp.
- Emits at most one entry per fe_clk cycle.
- Owns capture sequencing: arm, first-event start, length limit, and timestamp compression.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16: width of the full timestamp and of the inter-entry cycle counter.
- pTIMESTAMP_SHORT_WIDTH, 3: width of the short time field carried in DATA/STAT entries.

Ports:
- fe_clk  in  1  front-end clock.
- reset_i  in  1  synchronous, active-high reset.
- I_arm  in  1  capture arm from the register block; level-sensitive.
- I_timestamps_disable  in  1  1 = short time forced to 0 and no TIME entries are emitted.
- I_capture_len  in  16  maximum number of entries to emit; 0 = unlimited.
- I_fifo_full  in  1  sniff FIFO full flag.
- I_sniff_data  in  8  sniffed byte.
- I_sniff_valid  in  1  I_sniff_data is valid this cycle.
- I_sniff_stat  in  5  current line status.
- O_capture_time  out  pTIMESTAMP_FULL_WIDTH  entry time.
- O_capture_data  out  8  entry data byte.
- O_capture_stat  out  5  entry status.
- O_capture_cmd  out  2  entry command code: FE_FIFO_CMD_DATA, FE_FIFO_CMD_STAT or FE_FIFO_CMD_TIME.
- O_capture_data_wr  out  1  single-cycle entry strobe.
- O_capturing  out  1  high in WAIT_START, CAPTURE and TIME_PEND.
- O_done  out  1  capture length reached.
- O_dropped  out  1  sticky: an event was lost.

Behaviour:
- Reset: all outputs are 0, state is IDLE, ts=0, count=0, last_stat=0, hold register empty.
- States:
  - IDLE -> WAIT_START when I_arm=1. Entering WAIT_START clears O_dropped and count.
  - WAIT_START -> CAPTURE on the first event. An event is I_sniff_valid=1, or I_sniff_stat != last_stat. The first event is emitted with time 0, and ts is cleared.
  - CAPTURE: ts increments every cycle and saturates at all-ones. On an event, let d = ts:
    - If d <= 2^pTIMESTAMP_SHORT_WIDTH-1, or I_timestamps_disable=1: emit the event entry in the same cycle with time = d[short-1:0] (0 when disabled). ts <= 0.
    - Otherwise: emit a TIME entry with time = d, latch the event in the hold register, go to TIME_PEND, ts <= 0.
  - TIME_PEND: emit the held event with time 0, then return to CAPTURE. If a new event arrives in this cycle, it is dropped and O_dropped <= 1.
  - Idle overflow: in CAPTURE with no event and ts = all-ones, emit a TIME entry with time 0xFFFF and set ts <= 0. This is suppressed when timestamps are disabled.
  - DONE: entered after the entry that makes count == I_capture_len (I_capture_len != 0). O_done=1. DONE -> IDLE when I_arm=0.
- Any state -> IDLE when I_arm=0 (abort). A held event is discarded.
- Event entry types:
  - I_sniff_valid=1 -> DATA entry: data = byte, stat = I_sniff_stat.
  - Status change without valid -> STAT entry: data = 0, stat = new status.
  - Status change together with valid -> a single DATA entry only.
  - last_stat updates on every emitted DATA/STAT entry.
- Outputs are registered: the entry appears the cycle after the event; O_capture_data_wr is high for exactly 1 cycle per entry.
- count increments on every emitted entry, including TIME entries. A TIME entry that reaches the limit goes to DONE, and its held event is discarded.
- I_fifo_full=1: entries are still emitted (the register block blocks them and flags the overflow); count still increments.
- I_capture_len changes are only sampled while in IDLE.
- reset_i mid-capture returns to reset values on the next edge.

Test Plan:
- Arm, bytes 0x11 at t=0 and 0x22 at t=5 -> DATA(0x11, time 0), then DATA(0x22, time 5); O_capturing=1.
- Arm, byte at t=0, next byte at t=20 -> DATA(t0); TIME(20); DATA(time 0) one cycle later; count=3.
- Arm, one byte, then 70000 idle cycles -> one TIME(0xFFFF) entry, then a later event entry reflecting the remainder; no wr pulses in between.
- capture_len=4, 6 bytes spaced 2 cycles apart -> exactly 4 DATA entries, O_done=1, O_capturing=0; dropping I_arm -> IDLE, O_done=0.
- Status 0->3 with no data, then status 3->5 with a byte -> STAT(stat 3, data 0), then DATA(stat 5); timestamps_disable=1 gives time 0 for all entries and no TIME entries.
- Gap 9 then a byte, with another byte in the TIME_PEND cycle -> second byte lost, O_dropped=1; re-arm clears it.
